// File: rtl/beamform_pkg.sv
// Shared types and defaults for the beamformer threshold path.
package beamform_pkg;

  localparam int THRESH_BITS_DEF = 18;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_UPDATE = 2'd2,
    ST_HOLD   = 2'd3
  } thresh_state_e;

endpackage

// File: rtl/beam_thresh_shadow.sv
// Per-beam shadow/committed threshold registers with a registered readback port.
// Present only when BEAM_THRESH_READBACK_EN is defined.
`ifdef BEAM_THRESH_READBACK_EN
module beam_thresh_shadow #(
  parameter int NBEAMS      = 8,
  parameter int THRESH_BITS = 18
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NBEAMS-1:0]         wr_en,
  input  logic [THRESH_BITS-1:0]    wr_data,
  input  logic                      commit,
  input  logic [$clog2(NBEAMS)-1:0] rd_beam,
  output logic [THRESH_BITS-1:0]    rd_data
);

  localparam int IDX_BITS = $clog2(NBEAMS);
  localparam logic [IDX_BITS:0] BEAM_LIMIT = (IDX_BITS + 1)'(NBEAMS);

  logic [THRESH_BITS-1:0] shadow    [NBEAMS];
  logic [THRESH_BITS-1:0] committed [NBEAMS];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int b = 0; b < NBEAMS; b++) begin
        shadow[b]    <= '0;
        committed[b] <= '0;
      end
      rd_data <= '0;
    end else begin
      for (int b = 0; b < NBEAMS; b++) begin
        if (wr_en[b]) shadow[b] <= wr_data;
        if (commit)   committed[b] <= shadow[b];
      end
      // Out-of-range read indices return zero rather than an undefined entry.
      if ({1'b0, rd_beam} < BEAM_LIMIT) rd_data <= committed[rd_beam];
      else                              rd_data <= '0;
    end
  end

endmodule
`endif

// File: rtl/beam_thresh_loader.sv
// Streams per-beam thresholds into beamform_trigger and issues the apply pulse.
// Optional BEAM_THRESH_READBACK_EN adds rb_beam_i/rb_thresh_o for committed values.
//
// state  | meaning
// IDLE   | ready, waiting for a beat
// LOAD   | thresh_o and one-hot thresh_ce_o presented for one cycle
// UPDATE | update_o pulse, no load strobe
// HOLD   | settle for HOLD_CYCLES before accepting again
module beam_thresh_loader
  import beamform_pkg::*;
#(
  parameter int NBEAMS      = 8,
  parameter int THRESH_BITS = THRESH_BITS_DEF,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [THRESH_BITS-1:0]    s_thresh_tdata,
  input  logic [$clog2(NBEAMS)-1:0] s_thresh_tuser,
  input  logic                      s_thresh_tlast,
  input  logic                      s_thresh_tvalid,
  output logic                      s_thresh_tready,
  output logic [THRESH_BITS-1:0]    thresh_o,
  output logic [NBEAMS-1:0]         thresh_ce_o,
  output logic                      update_o,
`ifdef BEAM_THRESH_READBACK_EN
  input  logic [$clog2(NBEAMS)-1:0] rb_beam_i,
  output logic [THRESH_BITS-1:0]    rb_thresh_o,
`endif
  output logic                      busy_o,
  output logic                      err_o
);

  localparam int IDX_BITS = $clog2(NBEAMS);
  localparam int CNT_BITS = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [IDX_BITS:0]   BEAM_LIMIT = (IDX_BITS + 1)'(NBEAMS);
  localparam logic [CNT_BITS-1:0] HOLD_LOAD  = CNT_BITS'(HOLD_CYCLES);

  thresh_state_e state, state_next;

  logic [CNT_BITS-1:0]    hold_cnt, hold_cnt_next;
  logic                   last_q, last_next;
  logic [THRESH_BITS-1:0] thresh_next;
  logic [NBEAMS-1:0]      ce_next;
  logic                   update_next;
  logic                   err_next;
  logic                   accept;
  logic                   beam_ok;

  assign s_thresh_tready = (state == ST_IDLE) && !rst_i;
  assign accept          = s_thresh_tvalid && (state == ST_IDLE);
  assign beam_ok         = ({1'b0, s_thresh_tuser} < BEAM_LIMIT);
  assign busy_o          = (state != ST_IDLE);

  always_comb begin
    state_next    = state;
    hold_cnt_next = hold_cnt;
    last_next     = last_q;
    thresh_next   = thresh_o;
    ce_next       = '0;
    update_next   = 1'b0;
    err_next      = err_o;

    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          state_next  = ST_LOAD;
          last_next   = s_thresh_tlast;
          thresh_next = s_thresh_tdata;
          // A bad index is still consumed so its tlast can commit the batch.
          if (beam_ok) ce_next  = NBEAMS'(1) << s_thresh_tuser;
          else         err_next = 1'b1;
        end
      end
      ST_LOAD: begin
        if (last_q) begin
          state_next  = ST_UPDATE;
          update_next = 1'b1;
        end else begin
          state_next  = ST_IDLE;
        end
      end
      ST_UPDATE: begin
        if (HOLD_CYCLES == 0) begin
          state_next = ST_IDLE;
        end else begin
          state_next    = ST_HOLD;
          hold_cnt_next = HOLD_LOAD;
        end
      end
      ST_HOLD: begin
        hold_cnt_next = hold_cnt - 1'b1;
        if (hold_cnt <= CNT_BITS'(1)) begin
          state_next    = ST_IDLE;
          hold_cnt_next = '0;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      hold_cnt    <= '0;
      last_q      <= 1'b0;
      thresh_o    <= '0;
      thresh_ce_o <= '0;
      update_o    <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      state       <= state_next;
      hold_cnt    <= hold_cnt_next;
      last_q      <= last_next;
      thresh_o    <= thresh_next;
      thresh_ce_o <= ce_next;
      update_o    <= update_next;
      err_o       <= err_next;
    end
  end

`ifdef BEAM_THRESH_READBACK_EN
  beam_thresh_shadow #(
    .NBEAMS      (NBEAMS),
    .THRESH_BITS (THRESH_BITS)
  ) u_shadow (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .wr_en   (thresh_ce_o),
    .wr_data (thresh_o),
    .commit  (update_o),
    .rd_beam (rb_beam_i),
    .rd_data (rb_thresh_o)
  );
`endif

endmodule

// File: tb/tb_beam_thresh_loader.sv
// Directed bench for beam_thresh_loader: default instance plus a 6-beam, zero-hold instance.
module tb_beam_thresh_loader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [17:0] a_tdata, a_thresh;
  logic [2:0]  a_tuser;
  logic        a_tlast, a_tvalid, a_tready, a_update, a_busy, a_err;
  logic [7:0]  a_ce;

  logic [17:0] b_tdata, b_thresh;
  logic [2:0]  b_tuser;
  logic        b_tlast, b_tvalid, b_tready, b_update, b_busy, b_err;
  logic [5:0]  b_ce;

`ifdef BEAM_THRESH_READBACK_EN
  logic [2:0]  a_rb_beam, b_rb_beam;
  logic [17:0] a_rb_thresh, b_rb_thresh;
`endif

  beam_thresh_loader dut_a (
    .clk_i(clk), .rst_i(rst),
    .s_thresh_tdata(a_tdata), .s_thresh_tuser(a_tuser), .s_thresh_tlast(a_tlast),
    .s_thresh_tvalid(a_tvalid), .s_thresh_tready(a_tready),
    .thresh_o(a_thresh), .thresh_ce_o(a_ce), .update_o(a_update),
`ifdef BEAM_THRESH_READBACK_EN
    .rb_beam_i(a_rb_beam), .rb_thresh_o(a_rb_thresh),
`endif
    .busy_o(a_busy), .err_o(a_err)
  );

  // Six beams so that a 3-bit tuser can carry an out-of-range index.
  beam_thresh_loader #(.NBEAMS(6), .HOLD_CYCLES(0)) dut_b (
    .clk_i(clk), .rst_i(rst),
    .s_thresh_tdata(b_tdata), .s_thresh_tuser(b_tuser), .s_thresh_tlast(b_tlast),
    .s_thresh_tvalid(b_tvalid), .s_thresh_tready(b_tready),
    .thresh_o(b_thresh), .thresh_ce_o(b_ce), .update_o(b_update),
`ifdef BEAM_THRESH_READBACK_EN
    .rb_beam_i(b_rb_beam), .rb_thresh_o(b_rb_thresh),
`endif
    .busy_o(b_busy), .err_o(b_err)
  );

  task automatic test_reset();
    @(negedge clk);
    n_tests++; if (a_tready !== 1'b0) begin n_fail++; $display("FAIL reset_tready: got %b want 0", a_tready); end
    n_tests++; if (a_thresh !== 18'd0) begin n_fail++; $display("FAIL reset_thresh: got %0d want 0", a_thresh); end
    n_tests++; if (a_ce !== 8'h00) begin n_fail++; $display("FAIL reset_ce: got %h want 00", a_ce); end
    n_tests++; if (a_update !== 1'b0) begin n_fail++; $display("FAIL reset_update: got %b want 0", a_update); end
    n_tests++; if (a_busy !== 1'b0 || b_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b/%b want 0/0", a_busy, b_busy); end
    n_tests++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", a_err); end
    rst = 1'b0;
    #1;
    n_tests++; if (a_tready !== 1'b1) begin n_fail++; $display("FAIL release_tready: got %b want 1", a_tready); end
  endtask

`ifdef BEAM_THRESH_READBACK_EN
  task automatic test_readback();
    a_rb_beam = 3'd5;
    a_tdata = 18'd1234; a_tuser = 3'd5; a_tlast = 1'b0; a_tvalid = 1'b1;
    @(negedge clk);
    a_tvalid = 1'b0;
    @(negedge clk);
    n_tests++; if (a_rb_thresh !== 18'd0) begin n_fail++; $display("FAIL rb_uncommitted: got %0d want 0", a_rb_thresh); end
    a_tdata = 18'd1; a_tuser = 3'd0; a_tlast = 1'b1; a_tvalid = 1'b1;
    @(negedge clk);
    a_tvalid = 1'b0;
    repeat (6) @(negedge clk);
    n_tests++; if (a_rb_thresh !== 18'd1234) begin n_fail++; $display("FAIL rb_committed: got %0d want 1234", a_rb_thresh); end
  endtask
`endif

  task automatic test_single_beat();
    n_tests++; if (a_tready !== 1'b1) begin n_fail++; $display("FAIL single_ready0: got %b want 1", a_tready); end
    a_tdata = 18'd9000; a_tuser = 3'd3; a_tlast = 1'b1; a_tvalid = 1'b1;
    @(negedge clk);
    a_tvalid = 1'b0;
    n_tests++; if (a_thresh !== 18'd9000) begin n_fail++; $display("FAIL single_thresh: got %0d want 9000", a_thresh); end
    n_tests++; if (a_ce !== 8'b0000_1000) begin n_fail++; $display("FAIL single_ce: got %b want 00001000", a_ce); end
    n_tests++; if (a_update !== 1'b0 || a_tready !== 1'b0) begin n_fail++; $display("FAIL single_load_ctl: got upd=%b rdy=%b want 0/0", a_update, a_tready); end
    @(negedge clk);
    n_tests++; if (a_update !== 1'b1 || a_ce !== 8'h00) begin n_fail++; $display("FAIL single_update: got upd=%b ce=%h want 1/00", a_update, a_ce); end
    n_tests++; if (a_thresh !== 18'd9000) begin n_fail++; $display("FAIL single_thresh_hold: got %0d want 9000", a_thresh); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_tests++;
      if (a_tready !== 1'b0 || a_busy !== 1'b1 || a_update !== 1'b0) begin
        n_fail++; $display("FAIL single_hold%0d: got rdy=%b busy=%b upd=%b want 0/1/0", k, a_tready, a_busy, a_update);
      end
    end
    @(negedge clk);
    n_tests++; if (a_tready !== 1'b1 || a_busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: got rdy=%b busy=%b want 1/0", a_tready, a_busy); end
  endtask

  task automatic test_burst();
    int updates;
    updates = 0;
    a_tdata = 18'd0; a_tuser = 3'd0; a_tlast = 1'b0; a_tvalid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (a_update === 1'b1) updates++;
      n_tests++;
      if (a_ce !== 8'(1 << i) || a_thresh !== 18'(100 * i)) begin
        n_fail++; $display("FAIL burst_load%0d: got ce=%b thr=%0d want ce=%b thr=%0d", i, a_ce, a_thresh, 8'(1 << i), 100 * i);
      end
      if (i < 7) begin
        a_tdata = 18'(100 * (i + 1)); a_tuser = 3'(i + 1); a_tlast = (i == 6);
        @(negedge clk);
        if (a_update === 1'b1) updates++;
        n_tests++;
        if (a_ce !== 8'h00 || a_tready !== 1'b1) begin
          n_fail++; $display("FAIL burst_gap%0d: got ce=%b rdy=%b want 00000000/1", i, a_ce, a_tready);
        end
      end else begin
        a_tvalid = 1'b0;
      end
    end
    @(negedge clk);
    n_tests++; if (a_update !== 1'b1) begin n_fail++; $display("FAIL burst_update: got %b want 1", a_update); end
    if (a_update === 1'b1) updates++;
    repeat (5) begin
      @(negedge clk);
      if (a_update === 1'b1) updates++;
    end
    n_tests++; if (updates != 1) begin n_fail++; $display("FAIL burst_update_count: got %0d want 1", updates); end
  endtask

  task automatic test_same_beam();
    a_tdata = 18'd11; a_tuser = 3'd2; a_tlast = 1'b0; a_tvalid = 1'b1;
    @(negedge clk);
    n_tests++; if (a_ce !== 8'h04 || a_thresh !== 18'd11) begin n_fail++; $display("FAIL same_first: got ce=%h thr=%0d want 04/11", a_ce, a_thresh); end
    a_tdata = 18'd22; a_tlast = 1'b1;
    @(negedge clk);
    @(negedge clk);
    a_tvalid = 1'b0;
    n_tests++; if (a_ce !== 8'h04 || a_thresh !== 18'd22) begin n_fail++; $display("FAIL same_second: got ce=%h thr=%0d want 04/22", a_ce, a_thresh); end
    @(negedge clk);
    n_tests++; if (a_update !== 1'b1) begin n_fail++; $display("FAIL same_update: got %b want 1", a_update); end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_bad_index();
    b_tdata = 18'd555; b_tuser = 3'd7; b_tlast = 1'b0; b_tvalid = 1'b1;
    @(negedge clk);
    n_tests++; if (b_ce !== 6'b0 || b_err !== 1'b1 || b_busy !== 1'b1) begin n_fail++; $display("FAIL bad_load: got ce=%b err=%b busy=%b want 000000/1/1", b_ce, b_err, b_busy); end
    b_tdata = 18'd777; b_tuser = 3'd4; b_tlast = 1'b1;
    @(negedge clk);
    n_tests++; if (b_err !== 1'b1 || b_update !== 1'b0) begin n_fail++; $display("FAIL bad_idle: got err=%b upd=%b want 1/0", b_err, b_update); end
    @(negedge clk);
    n_tests++; if (b_ce !== 6'b010000 || b_thresh !== 18'd777) begin n_fail++; $display("FAIL bad_next_load: got ce=%b thr=%0d want 010000/777", b_ce, b_thresh); end
    b_tdata = 18'd999; b_tuser = 3'd6; b_tlast = 1'b1;
    @(negedge clk);
    n_tests++; if (b_update !== 1'b1 || b_ce !== 6'b0) begin n_fail++; $display("FAIL bad_next_update: got upd=%b ce=%b want 1/000000", b_update, b_ce); end
    @(negedge clk);
    n_tests++; if (b_tready !== 1'b1 || b_update !== 1'b0) begin n_fail++; $display("FAIL bad_nohold: got rdy=%b upd=%b want 1/0", b_tready, b_update); end
    @(negedge clk);
    b_tvalid = 1'b0;
    n_tests++; if (b_ce !== 6'b0 || b_err !== 1'b1) begin n_fail++; $display("FAIL bad_last_load: got ce=%b err=%b want 000000/1", b_ce, b_err); end
    @(negedge clk);
    n_tests++; if (b_update !== 1'b1) begin n_fail++; $display("FAIL bad_last_update: got %b want 1", b_update); end
    @(negedge clk);
    n_tests++; if (b_err !== 1'b1 || b_tready !== 1'b1) begin n_fail++; $display("FAIL bad_sticky: got err=%b rdy=%b want 1/1", b_err, b_tready); end
  endtask

  task automatic test_hold0_back_to_back();
    int first_k, second_k, count;
    first_k = -1; second_k = -1; count = 0;
    b_tdata = 18'd10; b_tuser = 3'd1; b_tlast = 1'b1; b_tvalid = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) begin b_tdata = 18'd20; b_tuser = 3'd2; end
      if (k == 4) b_tvalid = 1'b0;
      if (b_update === 1'b1) begin
        count++;
        if (first_k < 0) first_k = k;
        else if (second_k < 0) second_k = k;
      end
    end
    n_tests++; if (count != 2) begin n_fail++; $display("FAIL hold0_count: got %0d want 2", count); end
    n_tests++; if (second_k - first_k != 3) begin n_fail++; $display("FAIL hold0_spacing: got %0d want 3", second_k - first_k); end
  endtask

  task automatic test_reset_mid_op();
    int updates;
    updates = 0;
    a_tdata = 18'd4242; a_tuser = 3'd6; a_tlast = 1'b1; a_tvalid = 1'b1;
    @(negedge clk);
    a_tvalid = 1'b0;
    n_tests++; if (a_ce !== 8'h40) begin n_fail++; $display("FAIL rstmid_load: got ce=%h want 40", a_ce); end
    @(negedge clk);
    n_tests++; if (a_update !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre: got upd=%b want 1", a_update); end
    rst = 1'b1;
    #1;
    n_tests++; if (a_update !== 1'b0 || a_ce !== 8'h00 || a_thresh !== 18'd0) begin n_fail++; $display("FAIL rstmid_outputs: got upd=%b ce=%h thr=%0d want 0/00/0", a_update, a_ce, a_thresh); end
    n_tests++; if (a_busy !== 1'b0 || a_tready !== 1'b0) begin n_fail++; $display("FAIL rstmid_ctl: got busy=%b rdy=%b want 0/0", a_busy, a_tready); end
    n_tests++; if (b_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_err_clear: got %b want 0", b_err); end
    @(negedge clk);
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (a_update === 1'b1) updates++;
    end
    n_tests++; if (updates != 0) begin n_fail++; $display("FAIL rstmid_no_update: got %0d pulses want 0", updates); end
    n_tests++; if (a_tready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b want 1", a_tready); end
  endtask

  initial begin
    rst = 1'b1;
    a_tdata = '0; a_tuser = '0; a_tlast = 1'b0; a_tvalid = 1'b0;
    b_tdata = '0; b_tuser = '0; b_tlast = 1'b0; b_tvalid = 1'b0;
`ifdef BEAM_THRESH_READBACK_EN
    a_rb_beam = '0; b_rb_beam = '0;
`endif
    test_reset();
`ifdef BEAM_THRESH_READBACK_EN
    test_readback();
`endif
    test_single_beat();
    test_burst();
    test_same_beam();
    test_bad_index();
    test_hold0_back_to_back();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
